// File: rtl/cla_pkg.sv
// Shared types and helpers for the Kogge-Stone prefix adder: the (g, p) pair,
// the prefix combine operator and level/span derivation.
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Associative prefix operator: hi covers the more significant bit range.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

    function automatic int levels_for(input int width);
        return $clog2(width);
    endfunction

    // Distance between combined bits at prefix level l (1-based).
    function automatic int level_span(input int l);
        return 1 << (l - 1);
    endfunction

endpackage

// File: rtl/cla_gen_prop.sv
// Two-input generate/propagate combine cell used at every prefix node.
module cla_gen_prop
    import cla_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t res
);

    assign res = gp_combine(hi, lo);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined Kogge-Stone adder: pg stage, one register per prefix level and a
// registered sum stage, all advancing together under a global valid/ready stall.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = levels_for(WIDTH);

    logic             adv;
    logic [LEVELS:0]  valid_reg;
    gp_t              gp_reg   [0:LEVELS][WIDTH-1:0];
    gp_t              gp_next  [0:LEVELS][WIDTH-1:0];
    logic [WIDTH-1:0] p_reg    [0:LEVELS];
    logic             cin_reg  [0:LEVELS];
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] last_p_unused;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic             out_cout_reg;
    logic             out_ovf_reg;

    assign adv      = ~out_valid_reg | out_ready;
    assign in_ready = adv & ~rst;

    // Stage 0 inputs: bitwise g/p, with carry-in folded into bit 0's generate.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
            if (gi == 0) begin : g_bit0
                assign gp_next[0][gi] = '{g: (in_a[gi] & in_b[gi]) | ((in_a[gi] ^ in_b[gi]) & in_cin),
                                          p: in_a[gi] ^ in_b[gi]};
            end else begin : g_bitn
                assign gp_next[0][gi] = '{g: in_a[gi] & in_b[gi], p: in_a[gi] ^ in_b[gi]};
            end
        end
    endgenerate

    generate
        for (genvar li = 1; li <= LEVELS; li++) begin : g_level
            localparam int SPAN = level_span(li);
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_node
                if (gi >= SPAN) begin : g_comb
                    cla_gen_prop u_cell (
                        .hi  (gp_reg[li-1][gi]),
                        .lo  (gp_reg[li-1][gi-SPAN]),
                        .res (gp_next[li][gi])
                    );
                end else begin : g_pass
                    assign gp_next[li][gi] = gp_reg[li-1][gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (adv) begin
            valid_reg <= {valid_reg[LEVELS-1:0], in_valid & in_ready};
        end
    end

    // Datapath registers carry no reset; bubbles are tracked by valid_reg alone.
    always_ff @(posedge clk) begin
        if (adv) begin
            gp_reg[0]  <= gp_next[0];
            p_reg[0]   <= in_a ^ in_b;
            cin_reg[0] <= in_cin;
            for (int s = 1; s <= LEVELS; s++) begin
                gp_reg[s]  <= gp_next[s];
                p_reg[s]   <= p_reg[s-1];
                cin_reg[s] <= cin_reg[s-1];
            end
        end
    end

    // After the last level G_i is the carry into bit i+1; final P is not needed.
    assign carry[0] = cin_reg[LEVELS];
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
            assign carry[gi+1]       = gp_reg[LEVELS][gi].g;
            assign last_p_unused[gi] = gp_reg[LEVELS][gi].p;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_cout_reg  <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= valid_reg[LEVELS];
            out_sum_reg   <= p_reg[LEVELS] ^ carry[WIDTH-1:0];
            out_cout_reg  <= carry[WIDTH];
            out_ovf_reg   <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver queues expected results from an
// arithmetic reference, an independent monitor compares every presented output.
module tb_cla_pipe_adder;

    localparam int W   = 16;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference: plain integer addition on WIDTH+1 bits, overflow from operand signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input bit lat);
        exp_t         e;
        logic [W:0]   s;
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        e.acc  = 0;
        e.lat  = lat;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input exp_t e, output logic ready_first);
        int   guard;
        exp_t ent;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        ready_first = in_ready;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            ent     = e;
            ent.acc = cycle + 1;
            q.push_back(ent);
            $display("issue a=%h b=%h cin=%0d edge=%0d", a, b, c, ent.acc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit lat, output logic ready_first);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        send(a, b, c, model(a, b, c, lat), ready_first);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum=%h with no beat outstanding", out_sum);
                end else begin
                    e = q[0];
                    check("sum",  32'(out_sum),  32'(e.sum));
                    check("cout", 32'(out_cout), 32'(e.cout));
                    check("ovf",  32'(out_ovf),  32'(e.ovf));
                    if (out_ready) begin
                        if (e.lat) check("latency", 32'(cycle - e.acc), 32'(LAT));
                        $display("result sum=%h cout=%0d ovf=%0d edge=%0d", out_sum, out_cout, out_ovf, cycle);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic rdy;
        exp_t e;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd0);
        check("reset_out_sum",   32'(out_sum),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed corner cases with hand-computed expectations.
        e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, acc: 0, lat: 1'b1};
        send(16'hFFFF, 16'h0001, 1'b0, e, rdy);
        e = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, acc: 0, lat: 1'b1};
        send(16'h7FFF, 16'h0001, 1'b0, e, rdy);
        e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, acc: 0, lat: 1'b1};
        send(16'hFFFF, 16'h0000, 1'b1, e, rdy);
        e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b1, acc: 0, lat: 1'b1};
        send(16'h8000, 16'h8000, 1'b0, e, rdy);
        drain();

        // Back-to-back: results must come out on consecutive cycles at fixed latency.
        for (int i = 0; i < 8; i++) begin
            send_rand(1'b1, rdy);
            check("b2b_in_ready", 32'(rdy), 32'd1);
        end
        drain();

        // Consumer stall with a full pipe.
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand(1'b0, rdy);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready",  32'(in_ready),  32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight: none may emerge afterwards.
        for (int i = 0; i < 3; i++) send_rand(1'b0, rdy);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(16'h1234, 16'hEDCC, 1'b1, model(16'h1234, 16'hEDCC, 1'b1, 1'b1), rdy);
        check("post_rst_in_ready", 32'(rdy), 32'd1);
        drain();

        // Random traffic under random backpressure.
        fork
            begin
                for (int i = 0; i < 20; i++) send_rand(1'b0, rdy);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
